// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: core and debug/loader share one single-port memory.
// Round-robin on contention, with a bounded exclusive lock for debug bursts.
module dmem_arbiter #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic                clk,
  input  logic                rst,
  // core port
  input  logic                c_req,
  input  logic                c_we,
  input  logic [ADDR_W-1:0]   c_addr,
  input  logic [DATA_W-1:0]   c_wdata,
  input  logic [DATA_W/8-1:0] c_wstrb,
  output logic                c_gnt,
  output logic                c_rvalid,
  output logic [DATA_W-1:0]   c_rdata,
  // debug/loader port
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  input  logic                d_lock,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  // memory side
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned CNT_W  = $clog2(LOCK_MAX + 1);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] LAST_CORE = 2'd1;
  localparam logic [1:0] LAST_DBG  = 2'd2;
  localparam logic [1:0] LOCK      = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic             rvalid_q;
  logic             owner_q;
  logic             gnt_c, gnt_d;
  logic             lock_full;

  assign lock_full = (lock_cnt_q == CNT_W'(LOCK_MAX));

  always_comb begin
    gnt_c = 1'b0;
    gnt_d = 1'b0;
    if (!rst) begin
      if (state_q == LOCK && lock_full && c_req) begin
        gnt_c = 1'b1;
      end else if (state_q == LOCK && d_req && d_lock) begin
        gnt_d = 1'b1;
      end else if (c_req && d_req) begin
        // leaving LOCK falls through here and behaves like LAST_DBG
        if (state_q == LAST_CORE) gnt_d = 1'b1;
        else                      gnt_c = 1'b1;
      end else begin
        gnt_c = c_req;
        gnt_d = d_req;
      end
    end
  end

  always_comb begin
    state_d    = IDLE;
    lock_cnt_d = '0;
    if (gnt_c) begin
      state_d = LAST_CORE;
    end else if (gnt_d && d_lock) begin
      state_d = LOCK;
      if (state_q != LOCK) lock_cnt_d = CNT_W'(1);
      else if (lock_full)  lock_cnt_d = lock_cnt_q;
      else                 lock_cnt_d = lock_cnt_q + CNT_W'(1);
    end else if (gnt_d) begin
      state_d = LAST_DBG;
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    if (gnt_c) begin
      mem_we    = c_we;
      mem_addr  = c_addr;
      mem_wdata = c_wdata;
      mem_wstrb = c_wstrb;
    end else if (gnt_d) begin
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_wstrb = d_wstrb;
    end
  end

  assign c_gnt  = gnt_c;
  assign d_gnt  = gnt_d;
  assign mem_en = gnt_c | gnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      lock_cnt_q <= '0;
      rvalid_q   <= 1'b0;
      owner_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      rvalid_q   <= mem_en & ~mem_we;
      owner_q    <= gnt_d;
    end
  end

  // owner_q routes the one-cycle-late memory data back to whoever issued the read
  assign c_rvalid = rvalid_q & ~owner_q;
  assign d_rvalid = rvalid_q & owner_q;
  assign c_rdata  = c_rvalid ? mem_rdata : '0;
  assign d_rdata  = d_rvalid ? mem_rdata : '0;

  logic unused_strb_w;
  assign unused_strb_w = (STRB_W == 0);

endmodule
